// File: rtl/mod5_pkg.sv
// Shared constants and the mod-5 step function for the serial residue scheduler.
package mod5_pkg;

    localparam int MOD = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'(MOD - 1);

    // r' = (2r + b) mod 5; the unused codes 5..7 recover to R0
    function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
        logic [2:0] nxt;
        case (r)
            R0:      nxt = b ? R1 : R0;
            R1:      nxt = b ? R3 : R2;
            R2:      nxt = b ? R0 : R4;
            R3:      nxt = b ? R2 : R1;
            R4:      nxt = b ? R4 : R3;
            default: nxt = R0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mod5_residue_core.sv
// Bit-serial MSB-first mod-5 Moore engine with synchronous clear and enable.
module mod5_residue_core
    import mod5_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [2:0] rem
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem <= R0;
        end else if (clr) begin
            rem <= R0;
        end else if (en) begin
            rem <= mod5_step(rem, bit_in);
        end
    end

endmodule

// File: rtl/mod5_serial_sched.sv
// Round-robin sharing of one serial mod-5 engine between two word requesters.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | engine free; requests arbitrated and captured on this edge
//   S_SHIFT | shifting the captured word MSB-first through the engine
//   S_DONE  | one cycle, res_valid high, result registers updated
module mod5_serial_sched
    import mod5_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             res_valid,
    output logic             res_id,
    output logic [2:0]       residue
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] count;
    logic             rr_last;
    logic             res_id_pending;
    logic             grant_any;
    logic             grant_id;
    logic             last_bit;
    logic             first_shift;
    logic [2:0]       rem;

    // On a tie the requester that did not win last time is granted
    always_comb begin
        grant_any = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~rr_last;
        end else begin
            grant_id = req1;
        end
    end

    assign last_bit    = (count == CNT_W'(1));
    assign first_shift = (count == CNT_W'(WIDTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_any) state_nxt = S_SHIFT;
            S_SHIFT: if (last_bit)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ack is a Moore pulse during the first SHIFT cycle, i.e. right after capture
    always_comb begin
        busy      = 1'b0;
        res_valid = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        case (state)
            S_SHIFT: begin
                busy = 1'b1;
                if (first_shift) begin
                    ack0 = ~res_id_pending;
                    ack1 = res_id_pending;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg      <= '0;
            count          <= '0;
            rr_last        <= 1'b1;
            res_id_pending <= 1'b0;
            res_id         <= 1'b0;
            residue        <= R0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        shift_reg      <= grant_id ? data1 : data0;
                        count          <= CNT_W'(WIDTH);
                        rr_last        <= grant_id;
                        res_id_pending <= grant_id;
                    end
                end
                S_SHIFT: begin
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    count     <= count - CNT_W'(1);
                    if (last_bit) begin
                        residue <= mod5_step(rem, shift_reg[WIDTH-1]);
                        res_id  <= res_id_pending;
                    end
                end
                default: ;
            endcase
        end
    end

    mod5_residue_core u_core (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == S_IDLE),
        .en     (state == S_SHIFT),
        .bit_in (shift_reg[WIDTH-1]),
        .rem    (rem)
    );

endmodule

// File: tb/tb_mod5_serial_sched.sv
// Randomized and directed checks of the shared mod-5 scheduler against a word-level model.
module tb_mod5_serial_sched;

    localparam int W   = 8;
    localparam int W10 = 10;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic           req0  = 1'b0;
    logic           req1  = 1'b0;
    logic [W-1:0]   data0 = '0;
    logic [W-1:0]   data1 = '0;
    logic           ack0, ack1, busy, res_valid, res_id;
    logic [2:0]     residue;

    logic           t_req0  = 1'b0;
    logic           t_req1  = 1'b0;
    logic [W10-1:0] t_data0 = '0;
    logic [W10-1:0] t_data1 = '0;
    logic           t_ack0, t_ack1, t_busy, t_res_valid, t_res_id;
    logic [2:0]     t_residue;

    int checks = 0;
    int errors = 0;

    // word-level model: phase 0 = free, 1..W+1 = cycles since grant
    int phase    = 0;
    int rr_last  = 1;
    int pend_id  = 0;
    int pend_res = 0;
    int m_id     = 0;
    int m_res    = 0;

    always #5 clk = ~clk;

    mod5_serial_sched #(.WIDTH(W), .CNT_W(5)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .ack0      (ack0),
        .ack1      (ack1),
        .busy      (busy),
        .res_valid (res_valid),
        .res_id    (res_id),
        .residue   (residue)
    );

    mod5_serial_sched #(.WIDTH(W10), .CNT_W(5)) u_dut10 (
        .clk       (clk),
        .reset     (reset),
        .req0      (t_req0),
        .data0     (t_data0),
        .req1      (t_req1),
        .data1     (t_data1),
        .ack0      (t_ack0),
        .ack1      (t_ack1),
        .busy      (t_busy),
        .res_valid (t_res_valid),
        .res_id    (t_res_id),
        .residue   (t_residue)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase   = 0;
        rr_last = 1;
        m_id    = 0;
        m_res   = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack0"}, int'(ack0), 0);
        chk({tag, "_ack1"}, int'(ack1), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_valid"}, int'(res_valid), 0);
        chk({tag, "_id"}, int'(res_id), 0);
        chk({tag, "_res"}, int'(residue), 0);
    endtask

    // Advance one cycle, update the model from the requests seen at the edge, compare.
    task automatic step();
        int prev;
        int win;
        @(negedge clk);
        prev = phase;
        if (prev == 0) begin
            win = -1;
            if (req0 && req1) win = (rr_last == 1) ? 0 : 1;
            else if (req0)    win = 0;
            else if (req1)    win = 1;
            if (win >= 0) begin
                phase    = 1;
                pend_id  = win;
                pend_res = (win == 1) ? int'(data1) % 5 : int'(data0) % 5;
                rr_last  = win;
            end
        end else if (prev == W + 1) begin
            phase = 0;
        end else begin
            phase = prev + 1;
        end
        if (phase == W + 1) begin
            m_id  = pend_id;
            m_res = pend_res;
        end
        chk("ack0", int'(ack0), int'(phase == 1 && pend_id == 0));
        chk("ack1", int'(ack1), int'(phase == 1 && pend_id == 1));
        chk("busy", int'(busy), int'(phase != 0));
        chk("res_valid", int'(res_valid), int'(phase == W + 1));
        chk("res_id", int'(res_id), m_id);
        chk("residue", int'(residue), m_res);
    endtask

    function automatic logic [W-1:0] rand_word();
        int sel;
        sel = $urandom_range(7, 0);
        if (sel == 0) return '0;
        if (sel == 1) return '1;
        return W'($urandom);
    endfunction

    task automatic rand_drive();
        if (phase == 1 && pend_id == 0) begin
            if ($urandom_range(1, 0) == 1) req0 = 1'b0;
            else data0 = rand_word();
        end else if (!req0 && $urandom_range(2, 0) == 0) begin
            req0  = 1'b1;
            data0 = rand_word();
        end
        if (phase == 1 && pend_id == 1) begin
            if ($urandom_range(1, 0) == 1) req1 = 1'b0;
            else data1 = rand_word();
        end else if (!req1 && $urandom_range(2, 0) == 0) begin
            req1  = 1'b1;
            data1 = rand_word();
        end
    endtask

    initial begin
        int lat;
        bit seen;

        #3;
        chk_zero("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // single request from requester 0
        req0 = 1'b1; data0 = 8'd54;
        step();
        req0 = 1'b0;
        repeat (W + 3) step();
        chk("t54_res", int'(residue), 4);

        // single request from requester 1
        req1 = 1'b1; data1 = 8'd31;
        step();
        req1 = 1'b0;
        repeat (W + 3) step();
        chk("t31_res", int'(residue), 1);
        chk("t31_id", int'(res_id), 1);

        // both held from reset release: grants alternate 0,1,0,1
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        chk_zero("rst2");
        reset = 1'b1;
        req0 = 1'b1; data0 = 8'hFF;
        req1 = 1'b1; data1 = 8'h05;
        repeat (4 * (W + 2)) step();
        req0 = 1'b0; req1 = 1'b0;
        step();

        // reset during the 4th shift cycle aborts the word; held request reruns
        req0 = 1'b1; data0 = 8'd54;
        repeat (4) step();
        chk("mid_busy", int'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("mid_rst");
        model_reset();
        @(negedge clk);
        chk_zero("mid_hold");
        reset = 1'b1;
        step();
        req0 = 1'b0;
        repeat (W + 2) step();
        chk("rerun_res", int'(residue), 4);

        // data change during SHIFT is ignored
        req0 = 1'b1; data0 = 8'h1F;
        step();
        req0 = 1'b0;
        step();
        data0 = 8'h00;
        repeat (W + 1) step();
        chk("ignore_res", int'(residue), 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            rand_drive();
        end
        req0 = 1'b0; req1 = 1'b0;

        // 10-bit instance, 723 mod 5 = 3, result WIDTH cycles after the ack cycle
        t_req0 = 1'b1; t_data0 = 10'd723;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (t_ack0) seen = 1'b1;
        end
        chk("w10_ack", int'(seen), 1);
        t_req0 = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (t_res_valid) seen = 1'b1;
        end
        chk("w10_valid", int'(seen), 1);
        chk("w10_lat", lat, W10);
        chk("w10_res", int'(t_residue), 3);
        chk("w10_id", int'(t_res_id), 0);
        @(negedge clk);
        chk("w10_idle", int'(t_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
